bp_update_arbiter: RTL and testbench
====================================

Name: bp_update_arbiter

Overview:
- Serialises branch-resolution updates from the two execute lanes of the 2-way core onto the single update port of the meta/gshare/local predictor complex.
- Either lane, or both, may resolve a branch in one cycle. The predictor tables accept only one update per cycle.
- The block buffers resolved-branch records in a 2-push/1-pop FIFO, drains them oldest-first, and back-pressures issue when it cannot absorb two more records.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- REC_W, 66: update record width. Bit layout is in the shared package.

Ports:
- clk  in  1  core clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- upd0_valid  in  1  lane 0 (older slot) resolved a branch this cycle.
- upd0_mispredict  in  1  lane 0 branch mispredicted; the lane 1 record in the same cycle is wrong-path.
- upd0_rec  in  REC_W  lane 0 update record.
- upd1_valid  in  1  lane 1 (younger slot) resolved a branch this cycle.
- upd1_rec  in  REC_W  lane 1 update record.
- pred_ready  in  1  predictor accepts an update this cycle.
- pred_valid  out  1  head record is valid.
- pred_rec  out  REC_W  head record: taken, choose_G, meta index, GHPT index, GHR, G_BTB index, LHR index, LHPT index, L_BTB index, target.
- stall  out  1  fewer than 2 free entries; issue must hold branch dispatch.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a push was dropped because the FIFO was full.

Behaviour:
- Reset (Reset = 0, asynchronous):
  - wr_ptr, rd_ptr, count, overflow all 0.
  - Outputs are therefore pred_valid = 0, stall = 0.
  - Storage contents are don't-care.
- Push qualification:
  - p0 = upd0_valid.
  - p1 = upd1_valid & ~(upd0_valid & upd0_mispredict).
  - A lane 1 record following a mispredicted lane 0 branch is discarded silently and does not set overflow.
- Push order, within one cycle:
  - lane 0 record is written at wr_ptr.
  - lane 1 record is written at wr_ptr+1 if p0, else at wr_ptr.
  - This preserves program order.
- Pop: pop = pred_valid & pred_ready. rd_ptr advances by 1.
- Output timing:
  - pred_valid = (count != 0).
  - pred_rec = storage[rd_ptr], read combinationally from registered storage.
  - Minimum latency: a push in cycle N is visible at the output in cycle N+1. No same-cycle bypass.
- Occupancy:
  - count_next = count + p0 + p1 - pop.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Capacity:
  - Space for pushes = DEPTH - count + pop. The pop frees its slot in the same cycle.
  - Pushes beyond that space are dropped, lane 1 first.
  - Any drop sets overflow, which holds until reset.
  - count never exceeds DEPTH.
- stall = (DEPTH - count) < 2, computed from the registered count only (no pop look-ahead). This guarantees that a compliant upstream never overflows.
- Empty: pred_valid = 0 and pred_rec is don't-care.
- Full with pred_ready = 0: the FIFO holds and the head record stays stable until accepted.
- Simultaneous two pushes and one pop with count = DEPTH-1: legal. One push fits, plus the slot freed by the pop, so both pushes are accepted and count becomes DEPTH.
- Reset asserted mid-drain: the FIFO empties immediately and the pending updates are lost. This is acceptable because the predictor tables also reset.

Decomposition:
- Shared package bp_pkg holds:
  - REC_W.
  - Field offsets and widths: TAKEN, CHOOSE_G, META_IDX (5), GHPT_IDX (5), GHR (5), G_BTB_IDX (5), LHR_IDX (4), LHPT_IDX (4), L_BTB_IDX (4), TARGET (32).
  - A typedef/struct bp_update_t used by both lanes and by the predictor side.
- Sub-module bp_update_fifo2w: generic 2-write/1-read FIFO with storage, pointers and count.
- The top level adds the mispredict filter, stall generation and the overflow flag.

Test Plan:
1. Reset low, then release; upd1_valid=1 with rec target=0x0040_0020 and pred_ready=1 -> next cycle pred_valid=1 with that target; the following cycle count=0 and pred_valid=0.
2. Same cycle: upd0 target=0x100 and upd1 target=0x200, pred_ready=0 -> count=2; then with pred_ready=1, pred_rec shows 0x100 first and 0x200 on the next cycle.
3. upd0_valid=1, upd0_mispredict=1, upd1_valid=1 -> count increments by 1 only; only the lane 0 record appears; overflow stays 0.
4. pred_ready=0; push 1+1 -> count=2, stall=0; push 1 more -> count=3, stall=1; force a 2-push -> count=4, overflow=1, and the lane 1 record is never output.
5. count=3, pred_ready=1, 2 pushes -> count=4; pointer wrap past DEPTH-1 keeps FIFO order across 10 consecutive mixed cycles, checked by a scoreboard.
6. Reset asserted asynchronously mid-cycle with count=3 -> count, pred_valid, stall and overflow all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor update record: field widths, bit offsets and the
// packed struct exchanged between the execute lanes and the predictor complex.
package bp_pkg;

    localparam int TAKEN_W     = 1;
    localparam int CHOOSE_G_W  = 1;
    localparam int META_IDX_W  = 5;
    localparam int GHPT_IDX_W  = 5;
    localparam int GHR_W       = 5;
    localparam int G_BTB_IDX_W = 5;
    localparam int LHR_IDX_W   = 4;
    localparam int LHPT_IDX_W  = 4;
    localparam int L_BTB_IDX_W = 4;
    localparam int TARGET_W    = 32;

    localparam int TARGET_LSB    = 0;
    localparam int L_BTB_IDX_LSB = TARGET_LSB + TARGET_W;
    localparam int LHPT_IDX_LSB  = L_BTB_IDX_LSB + L_BTB_IDX_W;
    localparam int LHR_IDX_LSB   = LHPT_IDX_LSB + LHPT_IDX_W;
    localparam int G_BTB_IDX_LSB = LHR_IDX_LSB + LHR_IDX_W;
    localparam int GHR_LSB       = G_BTB_IDX_LSB + G_BTB_IDX_W;
    localparam int GHPT_IDX_LSB  = GHR_LSB + GHR_W;
    localparam int META_IDX_LSB  = GHPT_IDX_LSB + GHPT_IDX_W;
    localparam int CHOOSE_G_LSB  = META_IDX_LSB + META_IDX_W;
    localparam int TAKEN_LSB     = CHOOSE_G_LSB + CHOOSE_G_W;
    localparam int REC_W         = TAKEN_LSB + TAKEN_W;

    // First member is the MSB, so the layout matches the offsets above.
    typedef struct packed {
        logic                   taken;
        logic                   choose_g;
        logic [META_IDX_W-1:0]  meta_idx;
        logic [GHPT_IDX_W-1:0]  ghpt_idx;
        logic [GHR_W-1:0]       ghr;
        logic [G_BTB_IDX_W-1:0] g_btb_idx;
        logic [LHR_IDX_W-1:0]   lhr_idx;
        logic [LHPT_IDX_W-1:0]  lhpt_idx;
        logic [L_BTB_IDX_W-1:0] l_btb_idx;
        logic [TARGET_W-1:0]    target;
    } bp_update_t;

endpackage

// File: rtl/bp_update_arbiter_if.sv
// Bundle between the two execute lanes, the update arbiter and the predictor
// update port; slave is the arbiter's view, master the surrounding core's.
interface bp_update_arbiter_if #(
    parameter int DEPTH = 4
);
    import bp_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             upd0_valid;
    logic             upd0_mispredict;
    bp_update_t       upd0_rec;
    logic             upd1_valid;
    bp_update_t       upd1_rec;
    logic             pred_ready;
    logic             pred_valid;
    bp_update_t       pred_rec;
    logic             stall;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport slave (
        input  upd0_valid, upd0_mispredict, upd0_rec, upd1_valid, upd1_rec, pred_ready,
        output pred_valid, pred_rec, stall, count, overflow
    );

    modport master (
        output upd0_valid, upd0_mispredict, upd0_rec, upd1_valid, upd1_rec, pred_ready,
        input  pred_valid, pred_rec, stall, count, overflow
    );

endinterface

// File: rtl/bp_update_fifo2w.sv
// Generic 2-write/1-read FIFO. Writers must already be limited to free space
// and rd_en_i to a non-empty FIFO; the second write lands after the first.
module bp_update_fifo2w #(
    parameter  int DEPTH = 4,
    parameter  int W     = 66,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr0_en_i,
    input  logic [W-1:0]     wr0_data_i,
    input  logic             wr1_en_i,
    input  logic [W-1:0]     wr1_data_i,
    input  logic             rd_en_i,
    output logic [W-1:0]     rd_data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr1_ptr_s;
    logic [CNT_W-1:0] count_q, count_d;

    assign wr1_ptr_s = wr_ptr_q + PTR_W'(wr0_en_i);

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr0_en_i) + PTR_W'(wr1_en_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_i);
        count_d  = count_q + CNT_W'(wr0_en_i) + CNT_W'(wr1_en_i) - CNT_W'(rd_en_i);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; its contents are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr0_en_i) begin
            mem_q[wr_ptr_q] <= wr0_data_i;
        end
        if (wr1_en_i) begin
            mem_q[wr1_ptr_s] <= wr1_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/bp_update_arbiter.sv
// Serialises dual-lane branch-resolution updates onto the single predictor
// update port: mispredict filter, capacity check, stall and sticky overflow.
module bp_update_arbiter
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bp_update_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic             p0_s, p1_s;
    logic             acc0_s, acc1_s, drop_s;
    logic             valid_s, pop_s;
    logic [CNT_W-1:0] count_s, space_s;
    bp_update_t       head_s;
    logic             overflow_q, overflow_d;

    // A lane 1 record behind a mispredicted lane 0 branch is wrong-path.
    assign p0_s    = bus.upd0_valid;
    assign p1_s    = bus.upd1_valid & ~(bus.upd0_valid & bus.upd0_mispredict);
    assign valid_s = (count_s != {CNT_W{1'b0}});
    assign pop_s   = valid_s & bus.pred_ready;
    assign space_s = DEPTH_C - count_s + CNT_W'(pop_s);

    // Accept in program order; when space runs short lane 1 is dropped first.
    always_comb begin
        acc0_s = 1'b0;
        acc1_s = 1'b0;
        if (p0_s) begin
            acc0_s = (space_s >= ONE_C);
            acc1_s = p1_s & (space_s >= TWO_C);
        end else begin
            acc1_s = p1_s & (space_s >= ONE_C);
        end
        drop_s     = (p0_s & ~acc0_s) | (p1_s & ~acc1_s);
        overflow_d = overflow_q | drop_s;
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    bp_update_fifo2w #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr0_en_i   (acc0_s),
        .wr0_data_i (bus.upd0_rec),
        .wr1_en_i   (acc1_s),
        .wr1_data_i (bus.upd1_rec),
        .rd_en_i    (pop_s),
        .rd_data_o  (head_s),
        .count_o    (count_s)
    );

    assign bus.pred_valid = valid_s;
    assign bus.pred_rec   = head_s;
    assign bus.count      = count_s;
    assign bus.overflow   = overflow_q;
    // No pop look-ahead, so a compliant upstream can always land two records.
    assign bus.stall      = ((DEPTH_C - count_s) < TWO_C);

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Randomised scoreboard bench for bp_update_arbiter with a queue-based
// reference model and directed boundary sequences.
module tb_bp_update_arbiter;
    import bp_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_update_arbiter_if #(.DEPTH(DEPTH)) bus ();

    bp_update_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    bp_update_t sb_q[$];
    int         mdl_cnt     = 0;
    int         mdl_cnt_nxt = 0;
    bit         mdl_ovf     = 1'b0;
    bit         mdl_ovf_nxt = 1'b0;
    bit         mon_en      = 1'b0;
    bp_update_t nul;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bp_update_t mk_rec(input logic [31:0] tgt);
        logic [95:0] r;
        bp_update_t  rec;
        r          = {$urandom(), $urandom(), $urandom()};
        rec        = r[65:0];
        rec.target = tgt;
        return rec;
    endfunction

    // One clock of stimulus; the model applies the queue rules to the state after the last edge.
    task automatic cycle(input bit v0, input bit mp0, input bp_update_t r0,
                         input bit v1, input bp_update_t r1, input bit rdy,
                         input bit honor_stall);
        bp_update_t req[$];
        int         space;
        int         n_acc;
        bit         pop;
        @(posedge clk);
        #1;
        mdl_cnt = mdl_cnt_nxt;
        mdl_ovf = mdl_ovf_nxt;
        if (honor_stall && bus.stall) begin
            v0 = 1'b0;
            v1 = 1'b0;
        end
        bus.upd0_valid      = v0;
        bus.upd0_mispredict = mp0;
        bus.upd0_rec        = r0;
        bus.upd1_valid      = v1;
        bus.upd1_rec        = r1;
        bus.pred_ready      = rdy;
        pop = (mdl_cnt != 0) && rdy;
        if (v0) req.push_back(r0);
        if (v1 && !(v0 && mp0)) req.push_back(r1);
        space = DEPTH - mdl_cnt + (pop ? 1 : 0);
        n_acc = 0;
        foreach (req[i]) begin
            if (i < space) begin
                sb_q.push_back(req[i]);
                n_acc++;
            end else begin
                mdl_ovf_nxt = 1'b1;
            end
        end
        mdl_cnt_nxt = mdl_cnt - (pop ? 1 : 0) + n_acc;
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, nul, 1'b0, nul, rdy, 1'b0);
    endtask

    task automatic do_reset();
        mon_en              = 1'b0;
        rst_n               = 1'b0;
        bus.upd0_valid      = 1'b0;
        bus.upd0_mispredict = 1'b0;
        bus.upd1_valid      = 1'b0;
        bus.pred_ready      = 1'b0;
        sb_q.delete();
        mdl_cnt = 0; mdl_cnt_nxt = 0; mdl_ovf = 1'b0; mdl_ovf_nxt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: state checks every cycle, head record against the scoreboard, pop on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 96'(bus.count), 96'(mdl_cnt));
            chk("pred_valid", 96'(bus.pred_valid), 96'(mdl_cnt != 0));
            chk("stall", 96'(bus.stall), 96'((DEPTH - mdl_cnt) < 2));
            chk("overflow", 96'(bus.overflow), 96'(mdl_ovf));
            if (bus.pred_valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pred_rec: got %0h while no record is expected", bus.pred_rec);
                end else begin
                    chk("pred_rec", 96'(bus.pred_rec), 96'(sb_q[0]));
                    if (bus.pred_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        bp_update_t a, b;
        nul = '0;
        do_reset();

        // Single lane 1 record drains through with minimum latency.
        cycle(1'b0, 1'b0, nul, 1'b1, mk_rec(32'h0040_0020), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Dual push preserves program order.
        cycle(1'b1, 1'b0, mk_rec(32'h0000_0100), 1'b1, mk_rec(32'h0000_0200), 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Wrong-path lane 1 is filtered without touching overflow.
        cycle(1'b1, 1'b1, mk_rec(32'h0000_0300), 1'b1, mk_rec(32'h0000_0400), 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Fill to full, then force a drop of the lane 1 record.
        cycle(1'b1, 1'b0, mk_rec(32'h0000_1000), 1'b1, mk_rec(32'h0000_1001), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, mk_rec(32'h0000_1002), 1'b0, nul, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, mk_rec(32'h0000_1003), 1'b1, mk_rec(32'h0000_1004), 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("full_overflow", 96'(bus.overflow), 96'(1));

        // Pop once to reach count 3, then reset asynchronously mid-cycle.
        idle(1'b1);
        idle(1'b0);
        #1;
        chk("pre_reset_count", 96'(bus.count), 96'(3));
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_count", 96'(bus.count), 96'(0));
        chk("async_valid", 96'(bus.pred_valid), 96'(0));
        chk("async_stall", 96'(bus.stall), 96'(0));
        chk("async_overflow", 96'(bus.overflow), 96'(0));
        do_reset();

        // count = DEPTH-1 with two pushes and a pop: both accepted.
        cycle(1'b1, 1'b0, mk_rec(32'h0000_2000), 1'b0, nul, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, mk_rec(32'h0000_2001), 1'b1, mk_rec(32'h0000_2002), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, mk_rec(32'h0000_2003), 1'b1, mk_rec(32'h0000_2004), 1'b1, 1'b0);
        idle(1'b0);

        // Ten mixed cycles across the pointer wrap with a compliant upstream.
        for (int i = 0; i < 10; i++) begin
            a = mk_rec($urandom());
            b = mk_rec($urandom());
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), a,
                  1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)), 1'b1);
        end

        // Long random run, occasionally ignoring stall to provoke drops.
        for (int i = 0; i < 300; i++) begin
            a = mk_rec($urandom());
            b = mk_rec($urandom());
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), a,
                  1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) != 0));
        end

        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        @(negedge clk);
        #1;
        chk("sb_drained", 96'(sb_q.size()), 96'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
